// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with opcode-selected shifts, rotates and a self-timed serial burst load.
// Define USR_ROTATE_EN to compile the rotate opcodes; otherwise ROL/ROR hold the register.
module universal_shift_register #(
    parameter int WIDTH = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic [3:0]         ctrl,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               serial_data_input,
    input  logic [WIDTH-1:0]   parallel_data_input,
    output logic [WIDTH-1:0]   data_output,
    output logic               serial_data_output,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NONE       = 4'd0;
    localparam logic [3:0] OP_CLR        = 4'd1;
    localparam logic [3:0] OP_PLOAD      = 4'd2;
    localparam logic [3:0] OP_SMSB       = 4'd3;
    localparam logic [3:0] OP_SLSB       = 4'd4;
    localparam logic [3:0] OP_SHL        = 4'd5;
    localparam logic [3:0] OP_SHR        = 4'd6;
    localparam logic [3:0] OP_SAR        = 4'd7;
    localparam logic [3:0] OP_ROL        = 4'd8;
    localparam logic [3:0] OP_ROR        = 4'd9;
    localparam logic [3:0] OP_BURST_LOAD = 4'd10;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] q_next;
    logic             done_next;
    logic [WIDTH-1:0] msb_load, lsb_load, shl_val, shr_val, sar_val;

    // Shift amounts of WIDTH or more naturally yield zero / sign fill.
    assign msb_load = {serial_data_input, data_output[WIDTH-1:1]};
    assign lsb_load = {data_output[WIDTH-2:0], serial_data_input};
    assign shl_val  = data_output << shamt;
    assign shr_val  = data_output >> shamt;
    assign sar_val  = WIDTH'($signed(data_output) >>> shamt);

`ifdef USR_ROTATE_EN
    logic [SHAMT_W-1:0] rot_amt;
    logic [WIDTH-1:0]   rol_val, ror_val;

    assign rot_amt = SHAMT_W'(32'(shamt) % WIDTH);
    assign rol_val = (data_output << rot_amt) | (data_output >> (WIDTH - int'(rot_amt)));
    assign ror_val = (data_output >> rot_amt) | (data_output << (WIDTH - int'(rot_amt)));
`endif

    always_comb begin
        q_next     = data_output;
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        if (state == S_BURST) begin
            if (ctrl == OP_CLR) begin
                q_next     = '0;
                state_next = S_IDLE;
                cnt_next   = '0;
            end else begin
                q_next = msb_load;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
        end else begin
            case (ctrl)
                OP_CLR:   q_next = '0;
                OP_PLOAD: q_next = parallel_data_input;
                OP_SMSB:  q_next = msb_load;
                OP_SLSB:  q_next = lsb_load;
                OP_SHL:   q_next = shl_val;
                OP_SHR:   q_next = shr_val;
                OP_SAR:   q_next = sar_val;
`ifdef USR_ROTATE_EN
                OP_ROL:   q_next = rol_val;
                OP_ROR:   q_next = ror_val;
`endif
                // The accepting edge already captures the first burst bit.
                OP_BURST_LOAD: begin
                    q_next     = msb_load;
                    state_next = S_BURST;
                    cnt_next   = CNT_W'(1);
                end
                default: q_next = data_output;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            data_output <= '0;
            state       <= S_IDLE;
            cnt         <= '0;
            done        <= 1'b0;
        end else begin
            data_output <= q_next;
            state       <= state_next;
            cnt         <= cnt_next;
            done        <= done_next;
        end
    end

    assign busy               = (state == S_BURST);
    assign serial_data_output = data_output[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register: an arithmetic reference model predicts every cycle,
// a separate monitor pops and compares after each rising edge.
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int SW = $clog2(W);

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] CLR   = 4'd1;
    localparam logic [3:0] PLOAD = 4'd2;
    localparam logic [3:0] SHL   = 4'd5;
    localparam logic [3:0] SHR   = 4'd6;
    localparam logic [3:0] SAR   = 4'd7;
    localparam logic [3:0] ROL   = 4'd8;
    localparam logic [3:0] ROR   = 4'd9;
    localparam logic [3:0] BURST = 4'd10;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [3:0]    ctrl;
    logic [SW-1:0] shamt;
    logic          serial_data_input;
    logic [W-1:0]  parallel_data_input;
    logic [W-1:0]  data_output;
    logic          serial_data_output;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk                 (clk),
        .sync_reset          (sync_reset),
        .ctrl                (ctrl),
        .shamt               (shamt),
        .serial_data_input   (serial_data_input),
        .parallel_data_input (parallel_data_input),
        .data_output         (data_output),
        .serial_data_output  (serial_data_output),
        .busy                (busy),
        .done                (done)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    longint m_q    = 0;
    int     m_left = 0;
    bit     m_done = 1'b0;

    function automatic longint pow2(input int n);
        return longint'(1) << n;
    endfunction

    // Reference model: the word is a plain integer, shifts are multiply/divide, the burst is a count of bits still owed.
    task automatic model_step(input bit rst, input logic [3:0] c, input logic [SW-1:0] s,
                              input logic sdi, input logic [W-1:0] pdi);
        longint full = pow2(W);
        int     sh   = int'(s);
        int     r    = sh % W;
        longint msb_load = m_q / 2 + (sdi ? full / 2 : 0);
        if (rst) begin
            m_q = 0; m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_done = 1'b0;
            if (c == CLR) begin
                m_q = 0; m_left = 0;
            end else begin
                m_q = msb_load;
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            case (c)
                CLR:   m_q = 0;
                PLOAD: m_q = longint'(pdi);
                4'd3:  m_q = msb_load;
                4'd4:  m_q = (m_q * 2) % full + (sdi ? 1 : 0);
                SHL:   m_q = (sh >= W) ? 0 : (m_q * pow2(sh)) % full;
                SHR:   m_q = (sh >= W) ? 0 : m_q / pow2(sh);
                SAR:   begin
                    if (sh >= W) m_q = (m_q >= full / 2) ? full - 1 : 0;
                    else m_q = m_q / pow2(sh) + ((m_q >= full / 2) ? full - full / pow2(sh) : 0);
                end
`ifdef USR_ROTATE_EN
                ROL:   m_q = (m_q * pow2(r)) % full + m_q / pow2(W - r);
                ROR:   m_q = m_q / pow2(r) + (m_q % pow2(r)) * pow2(W - r);
`endif
                BURST: begin
                    m_q = msb_load;
                    m_left = W - 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input bit rst, input logic [3:0] c, input logic [SW-1:0] s,
                                 input logic sdi, input logic [W-1:0] pdi);
        exp_t e;
        sync_reset          = rst;
        ctrl                = c;
        shamt               = s;
        serial_data_input   = sdi;
        parallel_data_input = pdi;
        model_step(rst, c, s, sdi, pdi);
        e.q    = m_q[W-1:0];
        e.busy = (m_left > 0);
        e.done = m_done;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] exp_q,
                               input logic exp_busy, input logic exp_done);
        checks++;
        if (data_output !== exp_q || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("[TB] FAIL %s: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                     name, data_output, busy, done, exp_q, exp_busy, exp_done);
        end
    endtask

    // Monitor: one prediction is consumed per clock, sampled just after the edge.
    initial begin
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                got = sb.pop_front();
                checks++;
                if (data_output !== got.q || busy !== got.busy || done !== got.done ||
                    serial_data_output !== got.q[0]) begin
                    errors++;
                    $display("[TB] FAIL cycle_check @%0t: got q=%h sdo=%b busy=%b done=%b, expected q=%h sdo=%b busy=%b done=%b",
                             $time, data_output, serial_data_output, busy, done,
                             got.q, got.q[0], got.busy, got.done);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] bits;
        logic [3:0]   c;
        int           busy_cnt;
        int           done_cnt;
        int           guard;

        applyStimulus(1'b1, NONE, '0, 1'b0, '0);
        applyStimulus(1'b1, NONE, '0, 1'b0, '0);
        checkOutput("reset_initial", 8'h00, 1'b0, 1'b0);

        applyStimulus(1'b0, PLOAD, '0, 1'b0, 8'hA5);
        checkOutput("load_a5", 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b1, PLOAD, '0, 1'b0, 8'h3C);
        applyStimulus(1'b1, NONE, '0, 1'b0, '0);
        checkOutput("reset_after_load", 8'h00, 1'b0, 1'b0);

        applyStimulus(1'b0, PLOAD, '0, 1'b0, 8'h96);
        applyStimulus(1'b0, SAR, 3'd3, 1'b0, '0);
        checkOutput("sar3", 8'hF2, 1'b0, 1'b0);
        applyStimulus(1'b0, SHR, 3'd3, 1'b0, '0);
        checkOutput("shr3", 8'h1E, 1'b0, 1'b0);
        applyStimulus(1'b0, SHL, 3'd4, 1'b0, '0);
        checkOutput("shl4", 8'hE0, 1'b0, 1'b0);
        applyStimulus(1'b0, SAR, 3'd0, 1'b0, '0);
        checkOutput("sar_shamt0_hold", 8'hE0, 1'b0, 1'b0);

        applyStimulus(1'b0, PLOAD, '0, 1'b0, 8'h81);
        applyStimulus(1'b0, ROL, 3'd1, 1'b0, '0);
`ifdef USR_ROTATE_EN
        checkOutput("rol1", 8'h03, 1'b0, 1'b0);
        applyStimulus(1'b0, ROR, 3'd2, 1'b0, '0);
        checkOutput("ror2", 8'hC0, 1'b0, 1'b0);
`else
        checkOutput("rol_disabled_hold", 8'h81, 1'b0, 1'b0);
        applyStimulus(1'b0, ROR, 3'd2, 1'b0, '0);
        checkOutput("ror_disabled_hold", 8'h81, 1'b0, 1'b0);
`endif

        // Burst of 1,0,1,1,0,0,1,0; a BURST_LOAD mid-burst must be ignored.
        bits     = 8'b0100_1101;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < W; i++) begin
            c = (i == 0 || i == 3) ? BURST : NONE;
            applyStimulus(1'b0, c, '0, bits[i], 8'hFF);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        checkOutput("burst_result", 8'h4D, 1'b0, 1'b1);
        checks++;
        if (busy_cnt != W - 1) begin
            errors++;
            $display("[TB] FAIL burst_busy_cycles: got %0d, expected %0d", busy_cnt, W - 1);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL burst_done_pulses: got %0d, expected 1", done_cnt);
        end

        // Back-to-back bursts: the second is issued on the edge right after done rises.
        for (int j = 0; j < 2; j++) begin
            bits = W'($urandom);
            for (int i = 0; i < W; i++)
                applyStimulus(1'b0, (i == 0) ? BURST : NONE, '0, bits[i], '0);
            checkOutput(j == 0 ? "b2b_burst_first" : "b2b_burst_second", bits, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, NONE, '0, 1'b0, '0);
        checkOutput("done_clears", bits, 1'b0, 1'b0);

        applyStimulus(1'b0, BURST, '0, 1'b1, '0);
        applyStimulus(1'b0, NONE, '0, 1'b1, '0);
        applyStimulus(1'b0, NONE, '0, 1'b1, '0);
        applyStimulus(1'b0, CLR, '0, 1'b1, '0);
        checkOutput("burst_abort", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, '0, 1'b1, '0);
        checkOutput("abort_no_done", 8'h00, 1'b0, 1'b0);
        bits = W'($urandom);
        for (int i = 0; i < W; i++)
            applyStimulus(1'b0, (i == 0) ? BURST : NONE, '0, bits[i], '0);
        checkOutput("burst_after_abort", bits, 1'b0, 1'b1);

        applyStimulus(1'b0, BURST, '0, 1'b1, '0);
        applyStimulus(1'b0, NONE, '0, 1'b1, '0);
        applyStimulus(1'b1, NONE, '0, 1'b1, '0);
        checkOutput("reset_mid_burst", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, '0, 1'b1, '0);
        checkOutput("reset_mid_burst_no_done", 8'h00, 1'b0, 1'b0);

        // Random traffic; CLR is thinned out during bursts so most of them run to completion.
        for (int n = 0; n < 1000; n++) begin
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) c = BURST;
            if (m_left > 0 && c == CLR && $urandom_range(0, 3) != 0) c = NONE;
            applyStimulus($urandom_range(0, 49) == 0, c, SW'($urandom_range(0, W - 1)),
                          1'($urandom), W'($urandom));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
